// File: rtl/weight_buf_pkg.sv
// Shared types and default sizing for the conv-engine weight store.
// Imported by the weight buffer and by the conv engines that size their read ports.
package weight_buf_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } load_state_e;

  localparam int DEF_N_CH     = 3;
  localparam int DEF_WEIGHT_W = 90;
  localparam int DEF_DEPTH    = 32;
  localparam int BANKS        = 2;

endpackage

// File: rtl/weight_bank_ram.sv
// One channel of weight storage: both banks in a single array, one write
// and one registered read per cycle. The read register can be forced to zero.
module weight_bank_ram
  import weight_buf_pkg::*;
#(
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = $clog2(BANKS * DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WEIGHT_W-1:0] wdata,
  input  logic                re,
  input  logic                rzero,
  input  logic [AW-1:0]       raddr,
  output logic [WEIGHT_W-1:0] rdata
);

  localparam int WORDS = BANKS * DEPTH;

  logic [WEIGHT_W-1:0] mem_r [WORDS];
  logic [WEIGHT_W-1:0] rdata_r;

  // write port, contents deliberately left out of reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // registered read port; the masked case never touches the array
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      if (rzero) begin
        rdata_r <= '0;
      end else begin
        rdata_r <= mem_r[raddr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/weight_buffer.sv
// Ping-pong weight store: a set streams into the shadow bank while the conv
// datapath reads the active bank; a swap exchanges them between layers.
module weight_buffer
  import weight_buf_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [WEIGHT_W-1:0]      i_ld_data,
  input  logic                     i_ld_last,
  input  logic                     i_swap,
  input  logic                     i_rd_en,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic                     o_rd_valid,
  output logic [N_CH*WEIGHT_W-1:0] o_weight,
  output logic                     o_shadow_full,
  output logic                     o_active_valid,
  output logic                     o_swap_err
);

  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RAM_AW = ADDR_W + 1;

  localparam logic [RAM_AW-1:0] BANK_OFF  = RAM_AW'(DEPTH);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  load_state_e       state_r;
  logic [CH_W-1:0]   ch_cnt_r;
  logic [ADDR_W-1:0] addr_cnt_r;
  logic              active_bank_r;
  logic              active_valid_r;
  logic              ld_ready_r;
  logic              shadow_full_r;
  logic              swap_err_r;
  logic              rd_valid_r;

  logic              ld_hs_s;
  logic              set_done_s;
  logic [RAM_AW-1:0] wr_addr_s;
  logic [RAM_AW-1:0] rd_addr_s;
  logic              rd_zero_s;

  // handshake decode and bank-relative RAM addressing (bank b lives at b*DEPTH)
  always_comb begin
    ld_hs_s    = i_ld_valid & ld_ready_r & ~i_rst;
    set_done_s = i_ld_last | ((addr_cnt_r == ADDR_LAST) & (ch_cnt_r == CH_LAST));
    wr_addr_s  = active_bank_r ? {1'b0, addr_cnt_r} : ({1'b0, addr_cnt_r} + BANK_OFF);
    rd_addr_s  = active_bank_r ? ({1'b0, i_rd_addr} + BANK_OFF) : {1'b0, i_rd_addr};
    rd_zero_s  = ~active_valid_r | ({1'b0, i_rd_addr} >= BANK_OFF);
  end

  // load FSM, fill counters and bank select
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r        <= LOAD;
      ch_cnt_r       <= '0;
      addr_cnt_r     <= '0;
      active_bank_r  <= 1'b0;
      active_valid_r <= 1'b0;
      ld_ready_r     <= 1'b1;
      shadow_full_r  <= 1'b0;
      swap_err_r     <= 1'b0;
    end else begin
      swap_err_r <= 1'b0;
      case (state_r)
        LOAD: begin
          // nothing complete to swap in yet
          if (i_swap) begin
            swap_err_r <= 1'b1;
          end
          if (ld_hs_s) begin
            if (set_done_s) begin
              state_r       <= FULL;
              ld_ready_r    <= 1'b0;
              shadow_full_r <= 1'b1;
            end else if (ch_cnt_r == CH_LAST) begin
              ch_cnt_r   <= '0;
              addr_cnt_r <= addr_cnt_r + 1'b1;
            end else begin
              ch_cnt_r <= ch_cnt_r + 1'b1;
            end
          end
        end
        FULL: begin
          if (i_swap) begin
            state_r        <= LOAD;
            ld_ready_r     <= 1'b1;
            shadow_full_r  <= 1'b0;
            active_bank_r  <= ~active_bank_r;
            active_valid_r <= 1'b1;
            ch_cnt_r       <= '0;
            addr_cnt_r     <= '0;
          end
        end
        default: begin
          state_r       <= LOAD;
          ld_ready_r    <= 1'b1;
          shadow_full_r <= 1'b0;
          ch_cnt_r      <= '0;
          addr_cnt_r    <= '0;
        end
      endcase
    end
  end

  // read-valid tracks the RAM read register one cycle behind the request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= i_rd_en;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    weight_bank_ram #(
      .WEIGHT_W (WEIGHT_W),
      .DEPTH    (DEPTH),
      .AW       (RAM_AW)
    ) u_ram (
      .clk   (i_clk),
      .rst   (i_rst),
      .we    (ld_hs_s && (ch_cnt_r == CH_W'(ch))),
      .waddr (wr_addr_s),
      .wdata (i_ld_data),
      .re    (i_rd_en),
      .rzero (rd_zero_s),
      .raddr (rd_addr_s),
      .rdata (o_weight[ch*WEIGHT_W +: WEIGHT_W])
    );
  end

  assign o_ld_ready     = ld_ready_r;
  assign o_rd_valid     = rd_valid_r;
  assign o_shadow_full  = shadow_full_r;
  assign o_active_valid = active_valid_r;
  assign o_swap_err     = swap_err_r;

endmodule

// File: tb/tb_weight_buffer.sv
// Randomised scoreboard bench for weight_buffer: a word-indexed model of both
// banks predicts reads and status; a monitor pops expected reads on o_rd_valid.
module tb_weight_buffer;

  localparam int N  = 3;
  localparam int W  = 90;
  localparam int D  = 32;
  localparam int AW = 5;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_ld_valid = 1'b0;
  logic            o_ld_ready;
  logic [W-1:0]    i_ld_data = '0;
  logic            i_ld_last = 1'b0;
  logic            i_swap = 1'b0;
  logic            i_rd_en = 1'b0;
  logic [AW-1:0]   i_rd_addr = '0;
  logic            o_rd_valid;
  logic [N*W-1:0]  o_weight;
  logic            o_shadow_full;
  logic            o_active_valid;
  logic            o_swap_err;

  weight_buffer #(.N_CH(N), .WEIGHT_W(W), .DEPTH(D), .ADDR_W(AW)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_ld_valid     (i_ld_valid),
    .o_ld_ready     (o_ld_ready),
    .i_ld_data      (i_ld_data),
    .i_ld_last      (i_ld_last),
    .i_swap         (i_swap),
    .i_rd_en        (i_rd_en),
    .i_rd_addr      (i_rd_addr),
    .o_rd_valid     (o_rd_valid),
    .o_weight       (o_weight),
    .o_shadow_full  (o_shadow_full),
    .o_active_valid (o_active_valid),
    .o_swap_err     (o_swap_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: bank contents and buffer status at word-set granularity
  logic [W-1:0]   mem_m [2][D][N];
  int             m_wcnt;
  bit             m_full;
  bit             m_act;
  bit             m_actv;
  bit             m_serr;
  logic [N*W-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] model_read(input int addr);
    logic [N*W-1:0] r;
    r = '0;
    if (m_actv && addr < D) begin
      for (int c = 0; c < N; c++) r[c*W +: W] = mem_m[m_act][addr][c];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic chk_status();
    chk("ld_ready", N*W'(o_ld_ready), N*W'(!m_full));
    chk("shadow_full", N*W'(o_shadow_full), N*W'(m_full));
    chk("active_valid", N*W'(o_active_valid), N*W'(m_actv));
    chk("swap_err", N*W'(o_swap_err), N*W'(m_serr));
  endtask

  // one clock of stimulus; the model advances with the same edge
  task automatic cyc(input bit ld_v, input logic [W-1:0] d, input bit last,
                     input bit sw, input bit re, input int ra);
    bit hs;
    bit sw_ok;
    i_ld_valid = ld_v;
    i_ld_data  = d;
    i_ld_last  = last;
    i_swap     = sw;
    i_rd_en    = re;
    i_rd_addr  = AW'(ra);
    if (re) exp_q.push_back(model_read(ra));
    hs    = ld_v && !m_full;
    sw_ok = sw && m_full;
    @(posedge i_clk);
    #1;
    m_serr = sw && !m_full;
    if (sw_ok) begin
      m_act  = !m_act;
      m_actv = 1'b1;
      m_full = 1'b0;
      m_wcnt = 0;
    end
    if (hs) begin
      mem_m[!m_act][m_wcnt / N][m_wcnt % N] = d;
      if (last || m_wcnt == N*D - 1) m_full = 1'b1;
      else m_wcnt++;
    end
    chk_status();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_ld_valid = 1'b0; i_swap = 1'b0; i_rd_en = 1'b0; i_ld_last = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst  = 1'b0;
    m_wcnt = 0; m_full = 1'b0; m_act = 1'b0; m_actv = 1'b0; m_serr = 1'b0;
    chk_status();
    chk("rst_rd_valid", N*W'(o_rd_valid), '0);
    chk("rst_weight", o_weight, '0);
  endtask

  // monitor: every presented read must match the oldest expected result
  always @(negedge i_clk) begin
    if (o_rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_spurious: got o_rd_valid=1 expected no read pending");
      end else begin
        chk("rd_data", o_weight, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_i;
    int guard;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < D; a++)
        for (int c = 0; c < N; c++) mem_m[b][a][c] = '0;

    // reset state, then a read with nothing active returns zeros
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 0);
    idle();

    // full set with word k = k, swap, read addr 5
    for (int k = 0; k < N*D; k++) cyc(1'b1, W'(k), 1'b0, 1'b0, 1'b0, 0);
    chk("full_after_96", N*W'(o_shadow_full), N*W'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 5);
    chk("addr5_ch0", N*W'(o_weight[0 +: W]), N*W'(15));
    chk("addr5_ch1", N*W'(o_weight[W +: W]), N*W'(16));
    chk("addr5_ch2", N*W'(o_weight[2*W +: W]), N*W'(17));
    idle();

    // ping-pong: stream set B with gaps while reading every cycle
    rd_i  = 0;
    guard = 0;
    while (!m_full && guard < 3000) begin
      cyc(($urandom_range(0, 3) != 0), rnd_word(), 1'b0, 1'b0, 1'b1, rd_i % D);
      rd_i++;
      guard++;
    end
    chk("pingpong_fill_bound", N*W'(m_full), N*W'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, rd_i % D);
    rd_i++;
    for (int j = 0; j < 4; j++) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, rd_i % D);
      rd_i++;
    end
    idle();

    // early last on word 10; remaining shadow entries keep prior contents
    for (int k = 0; k <= 10; k++) cyc(1'b1, rnd_word(), (k == 10), 1'b0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 3);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 4);
    idle();

    // swap in LOAD after 20 words is ignored and loading resumes at word 20
    for (int k = 0; k < 20; k++) cyc(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 7);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 7);
    for (int k = 20; k < N*D; k++) cyc(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
    for (int a = 0; a < D; a += 5) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    idle();

    // reset mid-load, then a full reload is read back from word 0
    for (int k = 0; k < 40; k++) cyc(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 0);
    do_reset();
    for (int k = 0; k < N*D; k++) cyc(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 0);
    for (int a = 0; a < D; a++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    idle();
    idle();

    chk("reads_drained", N*W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_buffer.md
Name: weight_buffer

Overview:
- Parametrised, double-buffered (ping-pong) weight store for the depthwise/pointwise conv engines. Replaces the fixed 3-channel, 32-entry, 90-bit preloaded ROM.
- Weights for the next layer stream in through a valid/ready load port into the shadow bank. Meanwhile the conv datapath reads the active bank by opcode/address with a registered 1-cycle latency.
- A swap command exchanges the banks between layers.

Parameters:
- N_CH, 3, number of weight channels read in parallel.
- WEIGHT_W, 90, bits per channel word (3x3 kernel of 10-bit coefficients).
- DEPTH, 32, entries per channel per bank.
- ADDR_W, $clog2(DEPTH), read/load address width (5 at default).

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  synchronous, active-high reset.
- i_ld_valid  input  1  load word valid.
- o_ld_ready  output  1  buffer accepts load word.
- i_ld_data  input  WEIGHT_W  load word.
- i_ld_last  input  1  final word of this weight set (qualified by handshake).
- i_swap  input  1  one-cycle request to make the shadow bank active.
- i_rd_en  input  1  read request.
- i_rd_addr  input  ADDR_W  read address (opcode).
- o_rd_valid  output  1  o_weight valid (1 cycle after i_rd_en).
- o_weight  output  N_CH*WEIGHT_W  channel ch at bits [ch*WEIGHT_W +: WEIGHT_W].
- o_shadow_full  output  1  shadow set complete, awaiting swap.
- o_active_valid  output  1  active bank holds a swapped-in set.
- o_swap_err  output  1  one-cycle pulse: i_swap ignored.

Behaviour:
- Reset clears all registers:
  - load FSM = LOAD, ch_cnt = 0, addr_cnt = 0, active bank = 0.
  - o_rd_valid = 0, o_weight = 0, o_shadow_full = 0, o_active_valid = 0, o_swap_err = 0.
  - Memory contents are not cleared.
- Load FSM has two states: LOAD and FULL.
  - LOAD:
    - o_ld_ready = 1.
    - Handshake = i_ld_valid & o_ld_ready.
    - Each handshake writes i_ld_data to shadow bank, channel ch_cnt, entry addr_cnt.
    - Order is channel fastest: ch_cnt increments and wraps at N_CH-1, then addr_cnt increments.
    - Transition to FULL on a handshake with i_ld_last=1, or on the handshake at (addr_cnt=DEPTH-1, ch_cnt=N_CH-1), whichever comes first.
    - Entries not written by an early i_ld_last keep their previous contents.
  - FULL:
    - o_ld_ready = 0 and o_shadow_full = 1.
    - i_swap: next cycle the active bank toggles, o_active_valid = 1, FSM = LOAD, counters cleared.
- i_swap in LOAD: ignored; o_swap_err = 1 for the following cycle only; bank unchanged.
- Read path:
  - On i_rd_en, o_weight is registered from active bank entry i_rd_addr for all channels; o_rd_valid = 1 the next cycle.
  - Without i_rd_en, o_rd_valid = 0 and o_weight holds its last value.
  - Back-to-back reads sustain 1 result per cycle.
- Read boundary cases: o_weight returns all zeros (o_rd_valid still 1) when:
  - o_active_valid = 0, or
  - i_rd_addr >= DEPTH (possible when DEPTH is not a power of two).
- Simultaneous events:
  - i_rd_en in the same cycle as an accepted i_swap reads the old bank. The first read from the new bank is the next cycle.
  - A load write and a read in the same cycle always target different banks: no conflict.
- Reset mid-load discards the partial set: counters return to 0 and the set must be reloaded from word 0.
- Storage: 2*DEPTH words per channel, addressed {bank, addr}; one write and one read per cycle; infers block RAM.

Decomposition:
- Shared package weight_buf_pkg:
  - load-state enum (LOAD, FULL).
  - default N_CH/WEIGHT_W/DEPTH constants, shared with the conv engine.
  - localparam BANKS = 2.
- One sub-module weight_bank_ram: simple dual-port RAM with a 2*DEPTH x WEIGHT_W array, synchronous write and registered read, instantiated N_CH times.
- Top level holds the load FSM, counters, bank select and zero-masking.

Test Plan:
- Reset, then i_rd_en addr 0 -> next cycle o_rd_valid=1, o_weight=0, o_active_valid=0, o_ld_ready=1.
- Load 96 words, word k = k; then i_swap; then read addr 5.
  - o_shadow_full=1 and o_ld_ready=0 after the 96th handshake.
  - o_active_valid=1 one cycle after the swap.
  - Read addr 5 -> ch0=15, ch1=16, ch2=17, one cycle later.
- Ping-pong with set A active: stream set B with random i_ld_valid gaps while reading addr 0..31 every cycle.
  - All reads return A, including the read issued in the swap cycle.
  - The read issued the next cycle returns B.
- Early i_ld_last on word 10 (addr 3, ch1) -> FULL; swap; read addr 3 -> ch0 = word 9, ch1 = word 10, ch2 = prior contents.
- i_swap while in LOAD after 20 words -> o_swap_err pulses exactly 1 cycle, bank and counters unchanged, loading continues from word 20.
- Assert i_rst after 40 load words -> o_ld_ready=1 and o_active_valid=0. Reloading 96 words then swapping reads back the new data at word positions 0..95.
